bcd2bin_seq: RTL and testbench

- Iterative BCD-to-binary converter using reverse double dabble: shift right one bit per cycle, then subtract 3 from every BCD nibble that is 8 or greater.
- It is the inverse of the binary-to-BCD display path. It converts BCD values from the time-set path (keypad or up/down digit entry) into binary for the seconds, minutes and hours counters.
- Single start/busy/done handshake, with a registered result that is held until the next conversion.

---
 rtl/bcd_pkg.sv | 22 ++
 rtl/bcd2bin_seq_if.sv | 32 +++
 rtl/bcd2bin_seq_sub3.sv | 17 +
 rtl/bcd2bin_seq.sv | 135 +++++++++++++
 tb/tb_bcd2bin_seq.sv | 228 ++++++++++++++++++++++
 5 files changed

// File: rtl/bcd_pkg.sv
// rtl/bcd_pkg.sv - shared constants, FSM state type and digit check for the BCD converters
//
// Purpose: definitions shared by the BCD-to-binary converter, its interface
//          and its nibble correction cell.
// Ports:   none (package).

package bcd_pkg;

   localparam int NIBBLE_W = 4;

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      DONE
   } state_t;

   // True for a legal decimal digit 0..9.
   function automatic logic bcd_digit_valid(input logic [NIBBLE_W-1:0] nibble);
      return (nibble <= 4'd9);
   endfunction

endpackage

// File: rtl/bcd2bin_seq_if.sv
// rtl/bcd2bin_seq_if.sv - start/busy/done handshake and data bundle for bcd2bin_seq
//
// Purpose: groups the request (start, bcd) and result (busy, done, bin, err)
//          signals of the converter.
// Ports:   master - drives start/bcd, observes busy/done/bin/err.
//          slave  - the converter side.

interface bcd2bin_seq_if
   import bcd_pkg::*;
#(
   parameter int DIGITS = 2,
   parameter int BIN_W  = 7
);

   logic                       start;
   logic [NIBBLE_W*DIGITS-1:0] bcd;
   logic                       busy;
   logic                       done;
   logic [BIN_W-1:0]           bin;
   logic                       err;

   modport master (
      output start, bcd,
      input  busy, done, bin, err
   );

   modport slave (
      input  start, bcd,
      output busy, done, bin, err
   );

endinterface

// File: rtl/bcd2bin_seq_sub3.sv
// rtl/bcd2bin_seq_sub3.sv - reverse double dabble nibble correction cell
//
// Purpose: din >= 8 -> din - 3, otherwise din; undoes the add-3 step of the
//          binary-to-BCD path after each right shift.
// Ports:   din  - 4-bit nibble after the shift.
//          dout - corrected nibble.

module sub3
   import bcd_pkg::*;
(
   input  logic [NIBBLE_W-1:0] din,
   output logic [NIBBLE_W-1:0] dout
);

   assign dout = (din >= 4'd8) ? (din - 4'd3) : din;

endmodule

// File: rtl/bcd2bin_seq.sv
// rtl/bcd2bin_seq.sv - iterative BCD-to-binary converter (reverse double dabble)
//
// Purpose: converts a DIGITS-digit packed BCD value into BIN_W-bit binary,
//          one shift/correct iteration per clock, BIN_W iterations total.
// Ports:   clk   - system clock, rising edge.
//          reset - asynchronous, active-high reset.
//          bus   - slave side of bcd2bin_seq_if: start/bcd in,
//                  busy/done/bin/err out (bin/err held until next done).

module bcd2bin_seq
   import bcd_pkg::*;
#(
   parameter int DIGITS = 2,
   parameter int BIN_W  = 7
)
(
   input  logic          clk,
   input  logic          reset,
   bcd2bin_seq_if.slave  bus
);

   localparam int BCD_W = NIBBLE_W * DIGITS;
   localparam int SR_W  = BCD_W + BIN_W;
   localparam int CNT_W = $clog2(BIN_W + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIN_W - 1);

   // The largest BCD input (all nines) must fit in the result.
   if ((longint'(1) << BIN_W) <= (longint'(10) ** DIGITS - 1)) begin : g_bad_width
      $error("bcd2bin_seq: BIN_W too small for DIGITS");
   end

   state_t           state, state_n;
   logic [SR_W-1:0]  sr, sr_n;
   logic [CNT_W-1:0] cnt, cnt_n;
   logic             err_q, err_q_n;
   logic             busy_q, busy_n;
   logic             done_q, done_n;
   logic [BIN_W-1:0] bin_q, bin_n;
   logic             err_o_q, err_o_n;

   logic [SR_W-1:0]  sh;
   logic [BCD_W-1:0] fix_bcd;
   logic [SR_W-1:0]  sr_fix;
   logic             in_bad;

   // One iteration: shift right, then correct every BCD nibble independently.
   assign sh = sr >> 1;

   for (genvar g = 0; g < DIGITS; g++) begin : g_sub3
      sub3 u_sub3 (
         .din  (sh[BIN_W + g*NIBBLE_W +: NIBBLE_W]),
         .dout (fix_bcd[g*NIBBLE_W +: NIBBLE_W])
      );
   end

   assign sr_fix = {fix_bcd, sh[BIN_W-1:0]};

   always_comb begin
      in_bad = 1'b0;
      for (int i = 0; i < DIGITS; i++) begin
         if (!bcd_digit_valid(bus.bcd[i*NIBBLE_W +: NIBBLE_W])) begin
            in_bad = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state   <= IDLE;
         sr      <= '0;
         cnt     <= '0;
         err_q   <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         bin_q   <= '0;
         err_o_q <= 1'b0;
      end else begin
         state   <= state_n;
         sr      <= sr_n;
         cnt     <= cnt_n;
         err_q   <= err_q_n;
         busy_q  <= busy_n;
         done_q  <= done_n;
         bin_q   <= bin_n;
         err_o_q <= err_o_n;
      end
   end

   always_comb begin
      state_n = state;
      sr_n    = sr;
      cnt_n   = cnt;
      err_q_n = err_q;
      busy_n  = busy_q;
      done_n  = 1'b0;
      bin_n   = bin_q;
      err_o_n = err_o_q;

      case (state)
         IDLE: begin
            if (bus.start) begin
               sr_n    = {bus.bcd, {BIN_W{1'b0}}};
               cnt_n   = '0;
               err_q_n = in_bad;
               busy_n  = 1'b1;
               state_n = SHIFT;
            end
         end
         SHIFT: begin
            sr_n  = sr_fix;
            cnt_n = cnt + 1'b1;
            if (cnt == CNT_LAST) begin
               // An invalid digit still runs full length but reports zero.
               bin_n   = err_q ? '0 : sr_fix[BIN_W-1:0];
               err_o_n = err_q;
               done_n  = 1'b1;
               busy_n  = 1'b0;
               state_n = DONE;
            end
         end
         DONE: begin
            state_n = IDLE;
         end
         default: begin
            state_n = IDLE;
         end
      endcase
   end

   assign bus.busy = busy_q;
   assign bus.done = done_q;
   assign bus.bin  = bin_q;
   assign bus.err  = err_o_q;

endmodule

// File: tb/tb_bcd2bin_seq.sv
// tb/tb_bcd2bin_seq.sv - self-checking bench for bcd2bin_seq

module tb_bcd2bin_seq;

   localparam int DIGITS = 2;
   localparam int BIN_W  = 7;
   localparam int BCD_W  = 4 * DIGITS;

   logic clk   = 1'b0;
   logic reset = 1'b1;

   bcd2bin_seq_if #(.DIGITS(DIGITS), .BIN_W(BIN_W)) bus ();

   bcd2bin_seq #(.DIGITS(DIGITS), .BIN_W(BIN_W)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;
   int done_seen = 0;

   task automatic check(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Decimal value of the BCD word, or 0 when any digit is not 0..9.
   function automatic logic [BIN_W-1:0] ref_bin(input logic [BCD_W-1:0] b);
      int v;
      int dig;
      bit bad;
      v = 0;
      bad = 1'b0;
      for (int d = DIGITS - 1; d >= 0; d--) begin
         dig = int'(b[d*4 +: 4]);
         if (dig > 9) bad = 1'b1;
         v = v * 10 + dig;
      end
      return bad ? '0 : BIN_W'(v);
   endfunction

   function automatic logic ref_bad(input logic [BCD_W-1:0] b);
      logic bad;
      bad = 1'b0;
      for (int d = 0; d < DIGITS; d++) begin
         if (int'(b[d*4 +: 4]) > 9) bad = 1'b1;
      end
      return bad;
   endfunction

   // Timeline model: edge number of the accepting edge decides busy/done windows.
   int               cyc = 0;
   int               acc = 0;
   int               next_ok = 0;
   bit               acc_valid = 1'b0;
   logic [BIN_W-1:0] pend_bin = '0;
   logic             pend_err = 1'b0;
   logic [BIN_W-1:0] exp_bin = '0;
   logic             exp_err = 1'b0;

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         acc_valid <= 1'b0;
         next_ok   <= cyc;
         exp_bin   <= '0;
         exp_err   <= 1'b0;
      end else begin
         cyc <= cyc + 1;
         if (acc_valid && (cyc + 1 == acc + BIN_W)) begin
            exp_bin <= pend_bin;
            exp_err <= pend_err;
         end
         if ((cyc + 1 >= next_ok) && bus.start) begin
            pend_bin  <= ref_bin(bus.bcd);
            pend_err  <= ref_bad(bus.bcd);
            acc       <= cyc + 1;
            acc_valid <= 1'b1;
            next_ok   <= cyc + 1 + BIN_W + 2;
         end
      end
   end

   always @(negedge clk) begin
      bit eb;
      bit ed;
      eb = acc_valid && (cyc >= acc) && (cyc < acc + BIN_W);
      ed = acc_valid && (cyc == acc + BIN_W);
      check("busy", int'(bus.busy), int'(eb));
      check("done", int'(bus.done), int'(ed));
      check("bin",  int'(bus.bin),  int'(exp_bin));
      check("err",  int'(bus.err),  int'(exp_err));
      if (bus.done === 1'b1) done_seen++;
   end

   task automatic do_start(input logic [BCD_W-1:0] v);
      @(negedge clk);
      bus.start = 1'b1;
      bus.bcd   = v;
      @(negedge clk);
      bus.start = 1'b0;
   endtask

   // Counts cycles from the accepting edge until done is seen.
   task automatic wait_done(output int lat, output int at);
      lat = 0;
      while (bus.done !== 1'b1 && lat < 50) begin
         @(negedge clk);
         lat++;
      end
      at = cyc;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, expected finish before 100000");
      $fatal(1);
   end

   initial begin
      int lat;
      int d1;
      int d2;
      int s;

      bus.start = 1'b0;
      bus.bcd   = '0;
      repeat (3) @(negedge clk);
      check("rst_busy", int'(bus.busy), 0);
      check("rst_done", int'(bus.done), 0);
      check("rst_bin",  int'(bus.bin),  0);
      check("rst_err",  int'(bus.err),  0);
      reset = 1'b0;

      // 1: basic conversion
      do_start(8'h45);
      wait_done(lat, d1);
      check("t1_lat", lat, 7);
      check("t1_bin", int'(bus.bin), 45);
      check("t1_err", int'(bus.err), 0);

      // 2: boundary values
      do_start(8'h00);
      wait_done(lat, d1);
      check("t2_lat00", lat, 7);
      check("t2_bin00", int'(bus.bin), 0);
      do_start(8'h59);
      wait_done(lat, d1);
      check("t2_lat59", lat, 7);
      check("t2_bin59", int'(bus.bin), 59);
      do_start(8'h99);
      wait_done(lat, d1);
      check("t2_lat99", lat, 7);
      check("t2_bin99", int'(bus.bin), 99);

      // 3: invalid digit, then recovery
      do_start(8'h3A);
      wait_done(lat, d1);
      check("t3_lat3A", lat, 7);
      check("t3_bin3A", int'(bus.bin), 0);
      check("t3_err3A", int'(bus.err), 1);
      do_start(8'h23);
      wait_done(lat, d1);
      check("t3_bin23", int'(bus.bin), 23);
      check("t3_err23", int'(bus.err), 0);

      // 4: starts during SHIFT and DONE are ignored
      repeat (2) @(negedge clk);
      s = done_seen;
      do_start(8'h12);
      @(negedge clk);
      bus.start = 1'b1;
      bus.bcd   = 8'h77;
      @(negedge clk);
      bus.start = 1'b0;
      repeat (4) @(negedge clk);
      @(negedge clk);
      check("t4_done_at7", int'(bus.done), 1);
      bus.start = 1'b1;
      bus.bcd   = 8'h77;
      @(negedge clk);
      bus.start = 1'b0;
      repeat (12) @(negedge clk);
      check("t4_ndone", done_seen - s, 1);
      check("t4_bin", int'(bus.bin), 12);
      check("t4_busy", int'(bus.busy), 0);

      // 5: asynchronous reset mid-conversion
      do_start(8'h88);
      repeat (2) @(negedge clk);
      #2;
      reset = 1'b1;
      #1;
      check("t5_busy", int'(bus.busy), 0);
      check("t5_done", int'(bus.done), 0);
      check("t5_bin",  int'(bus.bin),  0);
      check("t5_err",  int'(bus.err),  0);
      @(negedge clk);
      reset = 1'b0;
      s = done_seen;
      repeat (12) @(negedge clk);
      check("t5_nodone", done_seen - s, 0);
      do_start(8'h31);
      wait_done(lat, d1);
      check("t5_lat31", lat, 7);
      check("t5_bin31", int'(bus.bin), 31);

      // 6: back-to-back conversions at minimum spacing
      do_start(8'h10);
      wait_done(lat, d1);
      check("t6_bin10", int'(bus.bin), 10);
      do_start(8'h24);
      wait_done(lat, d2);
      check("t6_bin24", int'(bus.bin), 24);
      check("t6_gap", d2 - d1, 9);

      repeat (4) @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
